ahb_lite_arb2: RTL

Two-master AHB-Lite arbiter that shares one `ahb_lite_sdram` slave port between two independent masters, e.g. a CPU and a DMA engine. It sits between the masters and the SDRAM bridge. Each master's address phase is captured into a per-port holding register. Captured transfers are issued to the slave one at a time under round-robin priority with HMASTLOCK reservation. Read data, write data and responses are routed back to the owning master.

---
 rtl/ahb_lite_arb_pkg.sv | 27 ++
 rtl/ahb_lite_arb_port.sv | 84 ++++++++
 rtl/ahb_lite_arb2.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_arb_pkg.sv
// Shared types and constants for the two-master AHB-Lite arbiter.
// Transfers are captured per port and replayed to the slave as single NONSEQ beats.
package ahb_lite_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Hold-register address width; top-level ADDR_W must not exceed it.
  localparam int ARB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ISSUED = 2'd2,
    DATA   = 2'd3
  } port_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [3:0]            prot;
    logic                  lock;
  } addr_phase_t;

endpackage

// File: rtl/ahb_lite_arb_port.sv
// One master-side port: captures an address phase, waits for grant and issue,
// then passes the slave data phase back to its master.
module ahb_lite_arb_port
  import ahb_lite_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [3:0]        hprot_i,
  input  logic              hmastlock_i,
  input  logic              grant_i,
  input  logic              s_hready_i,
  input  logic              s_hresp_i,
  output addr_phase_t       hold_o,
  output logic              hready_o,
  output logic              hresp_o,
  output port_state_t       state_o
);

  port_state_t state_q, state_d;
  addr_phase_t hold_q, hold_d;
  logic        capture;
  logic        unused_htrans;

  assign unused_htrans = htrans_i[0];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        capture = htrans_i[1];
      end
      PEND: begin
        hready_o = 1'b0;
        if (grant_i) state_d = ISSUED;
      end
      ISSUED: begin
        hready_o = 1'b0;
        if (s_hready_i) state_d = DATA;
      end
      DATA: begin
        hready_o = s_hready_i;
        hresp_o  = s_hresp_i;
        if (s_hready_i) begin
          state_d = IDLE;
          capture = htrans_i[1];
        end
      end
      default: state_d = IDLE;
    endcase
    // A completing data phase doubles as the next address phase.
    if (capture) begin
      state_d      = PEND;
      hold_d.addr  = ARB_ADDR_W'(haddr_i);
      hold_d.write = hwrite_i;
      hold_d.size  = hsize_i;
      hold_d.prot  = hprot_i;
      hold_d.lock  = hmastlock_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_o  = hold_q;
  assign state_o = state_q;

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter in front of one slave. Handshake: the slave address
// register advances, and a grant takes effect, only at edges where s_HREADYOUT=1.
module ahb_lite_arb2
  import ahb_lite_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic [1:0]        m0_HTRANS,
  input  logic              m0_HWRITE,
  input  logic [2:0]        m0_HSIZE,
  input  logic [2:0]        m0_HBURST,
  input  logic [3:0]        m0_HPROT,
  input  logic              m0_HMASTLOCK,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic [DATA_W-1:0] m0_HRDATA,
  output logic              m0_HREADY,
  output logic              m0_HRESP,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic [1:0]        m1_HTRANS,
  input  logic              m1_HWRITE,
  input  logic [2:0]        m1_HSIZE,
  input  logic [2:0]        m1_HBURST,
  input  logic [3:0]        m1_HPROT,
  input  logic              m1_HMASTLOCK,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic              m1_HREADY,
  output logic              m1_HRESP,
  output logic [ADDR_W-1:0] s_HADDR,
  output logic [1:0]        s_HTRANS,
  output logic              s_HWRITE,
  output logic [2:0]        s_HSIZE,
  output logic [2:0]        s_HBURST,
  output logic [3:0]        s_HPROT,
  output logic              s_HMASTLOCK,
  output logic              s_HSEL,
  output logic              s_HREADY,
  output logic [DATA_W-1:0] s_HWDATA,
  input  logic [DATA_W-1:0] s_HRDATA,
  input  logic              s_HREADYOUT,
  input  logic              s_HRESP
);

  addr_phase_t hold0, hold1, gnt_hold;
  port_state_t st0, st1;
  logic        rdy0, rdy1, resp0, resp1;
  logic        elig0, elig1, tie, gnt_vld, gnt_idx;
  logic        grant0, grant1;
  logic        unused_burst;

  addr_phase_t slv_q, slv_d;
  logic [1:0]  slv_trans_q, slv_trans_d;
  logic        slv_port_q, slv_port_d;
  logic        owner_vld_q, owner_vld_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic        lock_q, lock_d;
  logic        lock_port_q, lock_port_d;

  assign unused_burst = ^{m0_HBURST, m1_HBURST};

  ahb_lite_arb_port #(.ADDR_W(ADDR_W)) u_port0 (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .haddr_i     (m0_HADDR),
    .htrans_i    (m0_HTRANS),
    .hwrite_i    (m0_HWRITE),
    .hsize_i     (m0_HSIZE),
    .hprot_i     (m0_HPROT),
    .hmastlock_i (m0_HMASTLOCK),
    .grant_i     (grant0),
    .s_hready_i  (s_HREADYOUT),
    .s_hresp_i   (s_HRESP),
    .hold_o      (hold0),
    .hready_o    (rdy0),
    .hresp_o     (resp0),
    .state_o     (st0)
  );

  ahb_lite_arb_port #(.ADDR_W(ADDR_W)) u_port1 (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .haddr_i     (m1_HADDR),
    .htrans_i    (m1_HTRANS),
    .hwrite_i    (m1_HWRITE),
    .hsize_i     (m1_HSIZE),
    .hprot_i     (m1_HPROT),
    .hmastlock_i (m1_HMASTLOCK),
    .grant_i     (grant1),
    .s_hready_i  (s_HREADYOUT),
    .s_hresp_i   (s_HRESP),
    .hold_o      (hold1),
    .hready_o    (rdy1),
    .hresp_o     (resp1),
    .state_o     (st1)
  );

  // A locked port excludes the other until it issues an unlocked transfer.
  // The tie-break pointer moves only on contended grants, so the loser of
  // the previous tie wins the next one.
  always_comb begin
    elig0    = (st0 == PEND) && !(lock_q && lock_port_q);
    elig1    = (st1 == PEND) && !(lock_q && !lock_port_q);
    tie      = elig0 && elig1;
    gnt_vld  = elig0 || elig1;
    gnt_idx  = tie ? prio_q : elig1;
    gnt_hold = gnt_idx ? hold1 : hold0;
    grant0   = s_HREADYOUT && gnt_vld && !gnt_idx;
    grant1   = s_HREADYOUT && gnt_vld && gnt_idx;
  end

  always_comb begin
    slv_d       = slv_q;
    slv_trans_d = slv_trans_q;
    slv_port_d  = slv_port_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    if (s_HREADYOUT) begin
      owner_vld_d = slv_trans_q[1];
      owner_d     = slv_port_q;
      if (gnt_vld) begin
        slv_d       = gnt_hold;
        slv_trans_d = HTRANS_NONSEQ;
        slv_port_d  = gnt_idx;
        lock_d      = gnt_hold.lock;
        lock_port_d = gnt_idx;
        if (tie) prio_d = !gnt_idx;
      end else begin
        slv_d       = '0;
        slv_trans_d = HTRANS_IDLE;
        slv_port_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      slv_q       <= '0;
      slv_trans_q <= HTRANS_IDLE;
      slv_port_q  <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
    end else begin
      slv_q       <= slv_d;
      slv_trans_q <= slv_trans_d;
      slv_port_q  <= slv_port_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
    end
  end

  assign s_HADDR     = slv_q.addr[ADDR_W-1:0];
  assign s_HTRANS    = slv_trans_q;
  assign s_HWRITE    = slv_q.write;
  assign s_HSIZE     = slv_q.size;
  assign s_HBURST    = HBURST_SINGLE;
  assign s_HPROT     = slv_q.prot;
  assign s_HMASTLOCK = slv_q.lock;
  assign s_HSEL      = 1'b1;
  assign s_HREADY    = s_HREADYOUT;
  assign s_HWDATA    = !owner_vld_q ? '0 : (owner_q ? m1_HWDATA : m0_HWDATA);

  assign m0_HRDATA = s_HRDATA;
  assign m1_HRDATA = s_HRDATA;
  assign m0_HREADY = rdy0;
  assign m1_HREADY = rdy1;
  assign m0_HRESP  = resp0 && owner_vld_q && !owner_q;
  assign m1_HRESP  = resp1 && owner_vld_q && owner_q;

endmodule
